ioctl_sdram_loader: RTL and testbench

Packs the HPS ROM download byte stream (`ioctl_*`, index 0) into 32-bit little-endian words and writes them to the SDRAM controller through its req/ack port. It sits between `hps_io` and the `sdram` controller during download. While `busy` is high it owns the SDRAM port, and the game core's port is muxed out. It throttles the HPS through `ioctl_wait` with a 4-entry write FIFO and flushes any partial word when the download ends.

---
 rtl/ioctl_sdram_loader.sv | 177 +++++++++++++++++
 tb/tb_ioctl_sdram_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_sdram_loader.sv
// Packs the HPS download byte stream into 32-bit little-endian words and writes them to SDRAM.
// Enqueue happens on the strobe edge. The request follows one edge later. The HPS is stalled through ioctl_wait.
module ioctl_sdram_loader #(
  parameter logic [22:0] BASE_ADDR  = 23'd0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [19:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  input  logic        ioctl_download,
  output logic        ioctl_wait,
  output logic [22:0] sdram_addr,
  output logic [31:0] sdram_data,
  output logic        sdram_we,
  output logic        sdram_req,
  input  logic        sdram_ack,
  output logic        busy,
  output logic        done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] WAIT_C  = (PW+1)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

  state_t      state_q;
  logic        dl_q;
  logic [31:0] word_q;
  logic [3:0]  mask_q;
  logic [17:0] waddr_q;
  logic [49:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0] count_q;
  logic        overflow_q;
  logic        req_q, we_q, busy_q, done_q, wait_q;
  logic [22:0] addr_q;
  logic [31:0] data_q;

  logic [1:0]  lane;
  logic [4:0]  sh;
  logic [17:0] in_waddr;
  logic        wr_acc, flush_evt, jump, rise;
  logic        push, push_ok, drop, pop, full;
  logic [49:0] push_ent;
  logic [31:0] merged, word_d;
  logic [3:0]  mask_d;
  logic [17:0] waddr_d;
  logic [PW:0] count_d;

  // Assembly register: at most one FIFO push per cycle. A lane-3 byte that
  // arrives on an address jump is parked and pushed on the next quiet cycle.
  always_comb begin
    lane      = ioctl_addr[1:0];
    sh        = {lane, 3'b000};
    in_waddr  = ioctl_addr[19:2];
    wr_acc    = ioctl_wr && (state_q == S_LOAD || state_q == S_FLUSH);
    flush_evt = (state_q == S_LOAD && !ioctl_download) || state_q == S_FLUSH;
    jump      = wr_acc && (mask_q != 4'd0) && (waddr_q != in_waddr);
    rise      = ioctl_download && !dl_q;
    merged    = word_q;
    merged[sh +: 8] = ioctl_data;
    push      = 1'b0;
    push_ent  = {waddr_q, word_q};
    word_d    = word_q;
    mask_d    = mask_q;
    waddr_d   = waddr_q;
    if (jump) begin
      push    = 1'b1;
      word_d  = '0;
      word_d[sh +: 8] = ioctl_data;
      mask_d  = 4'b0001 << lane;
      waddr_d = in_waddr;
    end else if (wr_acc) begin
      if (lane == 2'd3 || flush_evt) begin
        push     = 1'b1;
        push_ent = {in_waddr, merged};
        word_d   = '0;
        mask_d   = 4'd0;
      end else begin
        word_d  = merged;
        mask_d  = mask_q | (4'b0001 << lane);
        waddr_d = in_waddr;
      end
    end else if (mask_q != 4'd0 && (flush_evt || mask_q[3])) begin
      push   = 1'b1;
      word_d = '0;
      mask_d = 4'd0;
    end
  end

  always_comb begin
    full    = (count_q == DEPTH_C);
    push_ok = push && !full;
    drop    = push && full;
    pop     = (count_q != '0) && (!req_q || sdram_ack);
    count_d = count_q;
    if (push_ok && !pop)
      count_d = count_q + 1'b1;
    else if (!push_ok && pop)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wptr_q] <= push_ent;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      dl_q       <= 1'b0;
      word_q     <= '0;
      mask_q     <= '0;
      waddr_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wait_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      dl_q    <= ioctl_download;
      word_q  <= word_d;
      mask_q  <= mask_d;
      waddr_q <= waddr_d;
      count_q <= count_d;
      wait_q  <= (count_d >= WAIT_C);
      if (push_ok)
        wptr_q <= wptr_q + 1'b1;
      // Back-to-back: the next entry replaces the acked one on the ack edge.
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
        addr_q <= BASE_ADDR + {5'd0, mem_q[rptr_q][49:32]};
        data_q <= mem_q[rptr_q][31:0];
        req_q  <= 1'b1;
        we_q   <= 1'b1;
      end else if (req_q && sdram_ack) begin
        req_q <= 1'b0;
        we_q  <= 1'b0;
      end
      overflow_q <= (overflow_q || drop) && !(state_q == S_IDLE && rise);
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: if (rise) begin
          state_q <= S_LOAD;
          busy_q  <= 1'b1;
        end
        S_LOAD: if (!ioctl_download)
          state_q <= S_FLUSH;
        S_FLUSH: if (count_q == '0 && !req_q && mask_q == 4'd0 && !push) begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ioctl_wait = wait_q;
  assign sdram_addr = addr_q;
  assign sdram_data = data_q;
  assign sdram_we   = we_q;
  assign sdram_req  = req_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Directed bench for ioctl_sdram_loader: an SDRAM responder with programmable ack hold and a write monitor.
module tb_ioctl_sdram_loader;

  logic        clk;
  logic        reset_n;
  logic [19:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic        ioctl_download;
  logic        ioctl_wait;
  logic [22:0] sdram_addr;
  logic [31:0] sdram_data;
  logic        sdram_we;
  logic        sdram_req;
  logic        sdram_ack;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int age = 0;
  logic ack_hold = 1'b0;
  logic [22:0] wa[$];
  logic [31:0] wd[$];

  ioctl_sdram_loader #(.BASE_ADDR(23'h100000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .ioctl_download(ioctl_download), .ioctl_wait(ioctl_wait),
    .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Controller model: ack on the third cycle a request is seen, unless held off.
  initial begin
    sdram_ack = 1'b0;
    forever begin
      @(posedge clk); #2;
      sdram_ack = 1'b0;
      if (sdram_req && !ack_hold) begin
        if (age == 2) begin
          sdram_ack = 1'b1;
          age = 0;
        end else age++;
      end else age = 0;
    end
  end

  always @(negedge clk) begin
    if (sdram_req && sdram_ack) begin
      wa.push_back(sdram_addr);
      wd.push_back(sdram_data);
      chk("we_with_req", {31'd0, sdram_we}, 32'd1);
    end
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [19:0] a, input logic [7:0] d);
    int n = 0;
    while (ioctl_wait && n < 1000) begin step(); n++; end
    if (n >= 1000) chk("wait_timeout", {31'd0, ioctl_wait}, 32'd0);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    step();
    ioctl_wr   = 1'b0;
  endtask

  task automatic start_dl();
    wa.delete();
    wd.delete();
    done_cnt = 0;
    ioctl_download = 1'b1;
    step();
  endtask

  task automatic finish_dl(input string tag);
    int n = 0;
    ioctl_download = 1'b0;
    step();
    while (busy && n < 3000) begin step(); n++; end
    chk(tag, {31'd0, busy}, 32'd0);
    repeat (3) step();
  endtask

  initial begin
    reset_n = 1'b0;
    ioctl_addr = '0;
    ioctl_data = '0;
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wait", {31'd0, ioctl_wait}, 32'd0);
    chk("rst_req",  {31'd0, sdram_req}, 32'd0);
    chk("rst_we",   {31'd0, sdram_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_addr", {9'd0, sdram_addr}, 32'd0);
    chk("rst_data", sdram_data, 32'd0);
    reset_n = 1'b1;
    repeat (2) step();

    // Sequential load with the first-word latency probed.
    start_dl();
    chk("t1_busy_rise", {31'd0, busy}, 32'd1);
    send_byte(20'd0, 8'h11);
    send_byte(20'd1, 8'h22);
    send_byte(20'd2, 8'h33);
    send_byte(20'd3, 8'h44);
    chk("t1_req_pre", {31'd0, sdram_req}, 32'd0);
    step();
    chk("t1_req_rise", {31'd0, sdram_req}, 32'd1);
    chk("t1_req_addr", {9'd0, sdram_addr}, 32'h100000);
    chk("t1_req_data", sdram_data, 32'h44332211);
    send_byte(20'd4, 8'h55);
    send_byte(20'd5, 8'h66);
    send_byte(20'd6, 8'h77);
    send_byte(20'd7, 8'h88);
    finish_dl("t1_busy_fall");
    chk("t1_nwr", wa.size(), 32'd2);
    if (wa.size() >= 2) begin
      chk("t1_a0", {9'd0, wa[0]}, 32'h100000);
      chk("t1_d0", wd[0], 32'h44332211);
      chk("t1_a1", {9'd0, wa[1]}, 32'h100001);
      chk("t1_d1", wd[1], 32'h88776655);
    end
    chk("t1_done_cnt", done_cnt, 32'd1);

    // Partial word flushed when the download ends.
    start_dl();
    for (int i = 0; i < 6; i++) send_byte(20'(i), 8'hA0 + 8'(i));
    finish_dl("t2_busy_fall");
    chk("t2_nwr", wa.size(), 32'd2);
    if (wa.size() >= 2) begin
      chk("t2_d0", wd[0], 32'hA3A2A1A0);
      chk("t2_a1", {9'd0, wa[1]}, 32'h100001);
      chk("t2_d1", wd[1], 32'h0000A5A4);
    end
    chk("t2_done_cnt", done_cnt, 32'd1);

    // Backpressure: acks withheld while 16 bytes stream in.
    ack_hold = 1'b1;
    start_dl();
    for (int i = 0; i < 15; i++) send_byte(20'(i), 8'hB0 + 8'(i));
    chk("t3_wait_pre", {31'd0, ioctl_wait}, 32'd0);
    send_byte(20'd15, 8'hBF);
    chk("t3_wait_rise", {31'd0, ioctl_wait}, 32'd1);
    repeat (180) step();
    chk("t3_req_held", {31'd0, sdram_req}, 32'd1);
    chk("t3_nwr_held", wa.size(), 32'd0);
    ack_hold = 1'b0;
    finish_dl("t3_busy_fall");
    chk("t3_nwr", wa.size(), 32'd4);
    if (wa.size() >= 4) begin
      chk("t3_a0", {9'd0, wa[0]}, 32'h100000);
      chk("t3_d0", wd[0], 32'hB3B2B1B0);
      chk("t3_a1", {9'd0, wa[1]}, 32'h100001);
      chk("t3_d1", wd[1], 32'hB7B6B5B4);
      chk("t3_a2", {9'd0, wa[2]}, 32'h100002);
      chk("t3_d2", wd[2], 32'hBBBAB9B8);
      chk("t3_a3", {9'd0, wa[3]}, 32'h100003);
      chk("t3_d3", wd[3], 32'hBFBEBDBC);
    end
    chk("t3_wait_end", {31'd0, ioctl_wait}, 32'd0);

    // Address jump flushes the partial word before the new word starts.
    start_dl();
    send_byte(20'd0, 8'h5A);
    send_byte(20'd1, 8'h6B);
    send_byte(20'd8, 8'h7C);
    step();
    chk("t4_req", {31'd0, sdram_req}, 32'd1);
    chk("t4_req_data", sdram_data, 32'h00006B5A);
    finish_dl("t4_busy_fall");
    chk("t4_nwr", wa.size(), 32'd2);
    if (wa.size() >= 2) begin
      chk("t4_a0", {9'd0, wa[0]}, 32'h100000);
      chk("t4_d0", wd[0], 32'h00006B5A);
      chk("t4_a1", {9'd0, wa[1]}, 32'h100002);
      chk("t4_d1", wd[1], 32'h0000007C);
    end

    // Reset while a request is outstanding, then a clean reload.
    ack_hold = 1'b1;
    start_dl();
    for (int i = 0; i < 4; i++) send_byte(20'(i), 8'hC0 + 8'(i));
    send_byte(20'd4, 8'hC4);
    chk("t5_req_pre", {31'd0, sdram_req}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_req_rst", {31'd0, sdram_req}, 32'd0);
    chk("t5_busy_rst", {31'd0, busy}, 32'd0);
    chk("t5_wait_rst", {31'd0, ioctl_wait}, 32'd0);
    chk("t5_we_rst", {31'd0, sdram_we}, 32'd0);
    ioctl_download = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    ack_hold = 1'b0;
    repeat (2) step();
    start_dl();
    for (int i = 0; i < 4; i++) send_byte(20'(i), 8'hD0 + 8'(i));
    finish_dl("t5_busy_fall");
    chk("t5_nwr", wa.size(), 32'd1);
    if (wa.size() >= 1) begin
      chk("t5_a0", {9'd0, wa[0]}, 32'h100000);
      chk("t5_d0", wd[0], 32'hD3D2D1D0);
    end

    // Stray strobes in IDLE are ignored.
    wa.delete();
    wd.delete();
    for (int i = 0; i < 4; i++) send_byte(20'(i + 3), 8'hEE);
    repeat (5) step();
    chk("t6_req", {31'd0, sdram_req}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_nwr", wa.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
